// File: rtl/uart_tx_block_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_block_if
// Purpose  : Host-side start/busy/done handshake for the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_block_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_abort;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        output tx_abort,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        input  tx_abort,
        output tx_busy,
        output tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_block.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_block
// Purpose  : UART transmitter: start bit, 8 data bits LSB first, optional even
//            parity (macro UART_TX_PARITY_EN), one stop bit; idle-high line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_block #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic           clk,
    input  logic           n_rst,
    uart_tx_block_if.slave host,
    output logic           serial_out
);
    localparam int            c_tw        = $clog2(CLKS_PER_BIT);
    localparam logic [c_tw-1:0] c_timer_max = c_tw'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [c_tw-1:0]   r_timer;
    logic [c_tw-1:0]   w_timer_nx;
    logic [2:0]        r_index;
    logic [2:0]        w_index_nx;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nx;
    logic              r_busy;
    logic              r_done;
    logic              w_done_nx;
    logic              w_serial_nx;
    logic              w_wrap;
    logic              w_accept;

    assign w_wrap   = (r_timer == c_timer_max);
    assign w_accept = (r_state == IDLE) && host.tx_start;

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // Parity is taken from the byte at acceptance because the shift register is consumed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^host.tx_data;
        end
    end
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = r_timer;
        w_index_nx  = r_index;
        w_shift_nx  = r_shift;
        w_done_nx   = 1'b0;
        w_serial_nx = 1'b1;

        if (r_state != IDLE) begin
            w_timer_nx = w_wrap ? '0 : r_timer + c_tw'(1);
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx = START;
                    w_timer_nx = '0;
                    w_index_nx = '0;
                    w_shift_nx = host.tx_data;
                end
            end
            START: begin
                if (w_wrap) w_state_nx = DATA;
            end
            DATA: begin
                if (w_wrap) begin
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_index_nx = r_index + 3'd1;
                    if (r_index == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = PARITY;
`else
                        w_state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_wrap) w_state_nx = STOP;
            end
`endif
            STOP: begin
                if (w_wrap) begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase

        // Abort outranks both a pending wrap and any start request.
        if (host.tx_abort && (r_state != IDLE)) begin
            w_state_nx = IDLE;
            w_timer_nx = '0;
            w_index_nx = '0;
            w_done_nx  = 1'b0;
        end

        // The line is registered, so it is decoded from the next state.
        case (w_state_nx)
            START:   w_serial_nx = 1'b0;
            DATA:    w_serial_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_serial_nx = r_parity;
`endif
            default: w_serial_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_index    <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_timer    <= w_timer_nx;
            r_index    <= w_index_nx;
            r_shift    <= w_shift_nx;
            r_busy     <= (w_state_nx != IDLE);
            r_done     <= w_done_nx;
            serial_out <= w_serial_nx;
        end
    end

    assign host.tx_busy = r_busy;
    assign host.tx_done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_block
// Purpose  : Scoreboard bench for uart_tx_block (C=10 and C=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_block;
`ifdef UART_TX_PARITY_EN
    localparam int N_BITS = 11;
`else
    localparam int N_BITS = 10;
`endif
    localparam int CS = 10;
    localparam int CF = 2;
    localparam int FS = N_BITS * CS;

    typedef struct {
        bit         sel;
        logic [7:0] data;
        int         e0;
        int         abort_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;
    logic ser_s;
    logic ser_f;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_e0 = 0;
    bit   mon_active = 1'b0;
    exp_t sb[$];

    uart_tx_block_if bus_s();
    uart_tx_block_if bus_f();

    uart_tx_block #(.CLKS_PER_BIT(CS)) dut_s (
        .clk        (clk),
        .n_rst      (n_rst),
        .host       (bus_s.slave),
        .serial_out (ser_s)
    );

    uart_tx_block #(.CLKS_PER_BIT(CF)) dut_f (
        .clk        (clk),
        .n_rst      (n_rst),
        .host       (bus_f.slave),
        .serial_out (ser_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic ab, input logic [7:0] d);
        if (sel) begin
            bus_f.tx_start = st; bus_f.tx_abort = ab; bus_f.tx_data = d;
        end else begin
            bus_s.tx_start = st; bus_s.tx_abort = ab; bus_s.tx_data = d;
        end
    endtask

    // Called at a negedge; the request is accepted on the next rising edge.
    task automatic launch(input bit sel, input logic [7:0] d, input int abort_off,
                          input bit push, input bit abort_too);
        exp_t e;
        e.sel       = sel;
        e.data      = d;
        e.e0        = cyc + 1;
        e.abort_cyc = (abort_off != 0) ? e.e0 + abort_off : 0;
        if (push) sb.push_back(e);
        drive(sel, 1'b1, abort_too, d);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, ~d);
        last_e0 = e.e0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_frame(input exp_t e);
        int   c, last, k, good_bd, tot_bd;
        int   good[12];
        int   tot[12];
        logic el, eb, ed, line, busy, done;
        c = e.sel ? CF : CS;
        last = (e.abort_cyc != 0) ? e.abort_cyc + c - 1 : e.e0 + N_BITS * c;
        good_bd = 0;
        tot_bd  = 0;
        for (int i = 0; i < 12; i++) begin
            good[i] = 0;
            tot[i]  = 0;
        end
        check($sformatf("frame %h start alignment", e.data), cyc, e.e0);
        for (int t = e.e0; t <= last; t++) begin
            line = e.sel ? ser_f : ser_s;
            busy = e.sel ? bus_f.tx_busy : bus_s.tx_busy;
            done = e.sel ? bus_f.tx_done : bus_s.tx_done;
            if (e.abort_cyc != 0 && t >= e.abort_cyc) begin
                k = N_BITS; el = 1'b1; eb = 1'b0; ed = 1'b0;
            end else begin
                k = (t - e.e0) / c;
                if (k >= N_BITS) begin
                    k = N_BITS; el = 1'b1; eb = 1'b0; ed = 1'b1;
                end else begin
                    el = exp_bit(e.data, k); eb = 1'b1; ed = 1'b0;
                end
            end
            tot[k]++;
            if (line === el) good[k]++;
            tot_bd++;
            if (busy === eb && done === ed) good_bd++;
            if (t != last) @(negedge clk);
        end
        for (int i = 0; i <= N_BITS; i++) begin
            if (tot[i] != 0)
                check($sformatf("frame %h C=%0d bit %0d correct cycles", e.data, c, i),
                      good[i], tot[i]);
        end
        check($sformatf("frame %h C=%0d busy/done correct cycles", e.data, c), good_bd, tot_bd);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            while (sb.size() == 0) @(negedge clk);
            e = sb.pop_front();
            mon_active = 1'b1;
            while (cyc < e.e0) @(negedge clk);
            check_frame(e);
            mon_active = 1'b0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int e0f, e0a, good, guard;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        @(negedge clk);
        check("reset serial C10", ser_s, 1);
        check("reset busy C10", bus_s.tx_busy, 0);
        check("reset done C10", bus_s.tx_done, 0);
        check("reset serial C2", ser_f, 1);
        check("reset busy C2", bus_f.tx_busy, 0);
        check("reset done C2", bus_f.tx_done, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of data bit 1.
        launch(1'b0, 8'h96, 0, 1'b0, 1'b0);
        wait_cyc(last_e0 + 25);
        check("busy before mid-frame reset", bus_s.tx_busy, 1);
        #2 n_rst = 1'b0;
        #1;
        check("async reset serial", ser_s, 1);
        check("async reset busy", bus_s.tx_busy, 0);
        check("async reset done", bus_s.tx_done, 0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        good = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ser_s === 1'b1 && bus_s.tx_busy === 1'b0 && bus_s.tx_done === 1'b0) good++;
        end
        check("idle cycles after reset release", good, 15);

        launch(1'b0, 8'hA5, 0, 1'b1, 1'b0);
        wait_cyc(last_e0 + FS + 3);
        launch(1'b0, 8'h07, 0, 1'b1, 1'b0);
        wait_cyc(last_e0 + FS + 3);

        // Busy rejection, then start held through the done cycle.
        launch(1'b0, 8'hFF, 0, 1'b1, 1'b0);
        e0f = last_e0;
        wait_cyc(e0f + 30);
        drive(1'b0, 1'b1, 1'b0, 8'h3C);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        wait_cyc(e0f + FS - 20);
        drive(1'b0, 1'b1, 1'b0, 8'h3C);
        wait_cyc(e0f + FS);
        sb.push_back('{sel: 1'b0, data: 8'h3C, e0: e0f + FS + 1, abort_cyc: 0});
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'hC3);
        wait_cyc(e0f + 2 * FS + 4);

        // Abort coinciding with the wrap that ends data bit 3.
        launch(1'b0, 8'h5A, 5 * CS, 1'b1, 1'b0);
        e0a = last_e0;
        wait_cyc(e0a + 5 * CS - 1);
        drive(1'b0, 1'b1, 1'b1, 8'h11);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        wait_cyc(e0a + 5 * CS + CS + 2);
        launch(1'b0, 8'hC3, 0, 1'b1, 1'b0);
        wait_cyc(last_e0 + FS + 3);

        // Abort while idle must not block a simultaneous start.
        launch(1'b0, 8'h81, 0, 1'b1, 1'b1);
        wait_cyc(last_e0 + FS + 3);

        launch(1'b1, 8'h00, 0, 1'b1, 1'b0);
        wait_cyc(last_e0 + N_BITS * CF + 3);

        guard = 0;
        while ((sb.size() != 0 || mon_active) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 2000) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_block.md
# uart_tx_block

Serial transmitter that converts a parallel byte into an asynchronous serial frame: start bit, 8 data bits LSB first, optional even parity bit, and one stop bit, with an idle-high line. It is the transmit-side counterpart of the team's UART receive path. A host loads bytes through a start/busy/done handshake. Bit timing and bit indexing run on internal counters built in the same style as the team's flexible counters.

## Interface
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range 2..1023.
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- tx_start  input  1  request to send `tx_data`; honoured only while `tx_busy`=0.
- tx_data  input  8  byte to transmit; captured on the accepting edge.
- tx_abort  input  1  synchronous abort; terminates the frame and returns the block to idle.
- serial_out  output  1  serial line; idle high; registered.
- tx_busy  output  1  high from the cycle after acceptance until the stop bit completes.
- tx_done  output  1  one-cycle pulse marking normal frame completion.

## Operation
- States: IDLE, START, DATA, PARITY (only when parity is compiled in), STOP.
- Internal counters:
  - Bit-timer, width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps.
  - 3-bit data index, 0..7.
  - 8-bit shift register loaded from `tx_data` on acceptance.
- IDLE: `serial_out`=1 and `tx_busy`=0. If `tx_start`=1, latch `tx_data`, clear both counters, and go to START.
- START: `serial_out`=0. When the bit-timer wraps, go to DATA.
- DATA:
  - `serial_out` = shift register bit 0.
  - On each bit-timer wrap, shift right and increment the index.
  - On the wrap with index=7, go to PARITY if compiled in, else STOP.
- PARITY: `serial_out` = XOR of the 8 latched bits (even parity). On wrap, go to STOP.
- STOP: `serial_out`=1. On wrap, go to IDLE and pulse `tx_done` for one cycle.
- `tx_start` while `tx_busy`=1 is ignored. No queuing.
- `tx_data` is don't-care outside the accepting edge.
- `tx_abort`=1 in any non-IDLE state:
  - Next cycle: IDLE, `serial_out`=1, `tx_busy`=0, no `tx_done`.
  - `tx_abort` has priority over `tx_start` and over a simultaneous bit-timer wrap.
- `tx_abort` in IDLE has no effect, and `tx_start` in the same cycle is still accepted.

## Timing
- Reset values: `serial_out`=1, `tx_busy`=0, `tx_done`=0, state IDLE, counters 0, shift register 0.
- `n_rst` low mid-frame forces the reset values immediately (asynchronously).
- Let the accepting edge be E0 and C = CLKS_PER_BIT.
- Frame bit k (k=0 is start) drives `serial_out` for exactly C cycles, from edge E0+k·C to edge E0+(k+1)·C.
- Frame length N is 10 bits, or 11 with parity.
- `tx_busy` rises after E0 and falls after edge E0+N·C.
- `tx_done` is high for exactly the one cycle after edge E0+N·C, concurrent with `tx_busy`=0.
- Back-to-back: `tx_start` held high during the `tx_done` cycle is accepted on that edge. Line gap between frames is 1 idle-high cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined:
  - PARITY state is present.
  - Even parity bit is inserted between data bit 7 and the stop bit.
  - Frame = 11·C cycles.
- Undefined:
  - PARITY state and parity logic are absent.
  - Frame = 10·C cycles.
  - The line goes directly from data bit 7 to the stop bit.

## Test plan
- Reset: assert `n_rst`=0 mid-DATA with C=10 -> `serial_out`=1, `tx_busy`=0, `tx_done`=0 immediately; after release, stays idle with no spurious `tx_done`.
- Single frame, no parity, C=10, `tx_data`=8'hA5 -> line shows 0, then 1,0,1,0,0,1,0,1, then 1, each held exactly 10 cycles; `tx_done` pulses once, 100 cycles after acceptance.
- Parity compiled in, C=10:
  - 8'hA5 -> parity bit 0, frame 110 cycles.
  - 8'h07 -> parity bit 1.
- Busy rejection and back-to-back: pulse `tx_start` with 8'h3C mid-frame of 8'hFF -> ignored, only 8'hFF sent; hold `tx_start` with 8'h3C through the `tx_done` cycle -> 8'h3C frame starts after a 1-cycle idle gap.
- Abort: assert `tx_abort` at DATA bit 3, same cycle as a bit-timer wrap -> next cycle `serial_out`=1, `tx_busy`=0, no `tx_done`; a new `tx_start` is then accepted normally.
- Minimum rate, C=2, `tx_data`=8'h00 -> every bit lasts exactly 2 cycles; frame = 20 cycles (22 with parity).
